// File: rtl/qspi_cdc_fifo_pkg.sv
// qspi_cdc_fifo_pkg: shared default geometry for the QSPI CDC/FIFO front end
package qspi_cdc_fifo_pkg;
    localparam int   DEF_WIDTH         = 16;
    localparam int   DEF_DEPTH         = 16;
    localparam logic DEF_TXNRESET_INIT = 1'b1;
endpackage

// File: rtl/qspi_cdc_fifo_edge.sv
// qspi_cdc_fifo_edge: synchronized level with rising/falling edge pulses
module qspi_cdc_fifo_edge (
    input  logic clk_i,
    input  logic reset_i,
    input  logic d_i,
    output logic q_o,
    output logic pe_o,
    output logic ne_o
);
    logic prev;
    qspi_cdc_fifo_sync #(.INIT(1'b0)) u_sync (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .d_i     (d_i),
        .q_o     (q_o)
    );
    // remember last synchronized level so edges last one cycle
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) prev <= 1'b0;
        else         prev <= q_o;
    end
    assign pe_o = q_o & ~prev;
    assign ne_o = ~q_o & prev;
endmodule

// File: rtl/qspi_cdc_fifo_fifo.sv
// qspi_cdc_fifo_fifo: synchronous FIFO with registered read data and flush
module qspi_cdc_fifo_fifo
    import qspi_cdc_fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       clear_i,
    input  logic                       wr_i,
    input  logic [WIDTH-1:0]           wr_data_i,
    input  logic                       rd_i,
    output logic [WIDTH-1:0]           rd_data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     filled_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic [CW-1:0]    count;
    logic             rd_ok, wr_ok;
    assign empty_o  = count == '0;
    assign full_o   = count == CW'(DEPTH);
    assign filled_o = count;
    assign rd_ok    = rd_i & ~empty_o;
    assign wr_ok    = wr_i & (~full_o | rd_ok);
    // storage array carries no reset; flush makes stale contents unreachable
    always_ff @(posedge clk_i) begin
        if (wr_ok && !clear_i) mem[wptr] <= wr_data_i;
    end
    // pointers, occupancy and registered head word; flush overrides traffic
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i || clear_i) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            rd_data_o <= '0;
        end else begin
            if (wr_ok) wptr <= wptr + AW'(1);
            if (rd_ok) begin
                rptr      <= rptr + AW'(1);
                rd_data_o <= mem[rptr];
            end
            count <= count + CW'(wr_ok) - CW'(rd_ok);
        end
    end
endmodule

// File: rtl/qspi_cdc_fifo_sync.sv
// qspi_cdc_fifo_sync: two-flop level synchronizer with configurable reset value
module qspi_cdc_fifo_sync #(
    parameter logic INIT = 1'b0
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic d_i,
    output logic q_o
);
    logic [1:0] stages;
    // shift the asynchronous level through two flops
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) stages <= {2{INIT}};
        else         stages <= {stages[0], d_i};
    end
    assign q_o = stages[1];
endmodule

// File: rtl/qspi_cdc_fifo.sv
// qspi_cdc_fifo: SPI-to-system CDC synchronizers plus read-data buffer FIFO
module qspi_cdc_fifo
    import qspi_cdc_fifo_pkg::*;
#(
    parameter int   WIDTH         = DEF_WIDTH,
    parameter int   DEPTH         = DEF_DEPTH,
    parameter logic TXNRESET_INIT = DEF_TXNRESET_INIT
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   done_async_i,
    output logic                   done_o,
    output logic                   done_pe_o,
    output logic                   done_ne_o,
    input  logic                   txnreset_async_i,
    output logic                   txnreset_o,
    input  logic                   fifo_clear_i,
    input  logic                   wr_i,
    input  logic [WIDTH-1:0]       wr_data_i,
    input  logic                   rd_i,
    output logic [WIDTH-1:0]       rd_data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] filled_o
);
    qspi_cdc_fifo_edge u_done (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .d_i     (done_async_i),
        .q_o     (done_o),
        .pe_o    (done_pe_o),
        .ne_o    (done_ne_o)
    );
    qspi_cdc_fifo_sync #(.INIT(TXNRESET_INIT)) u_txnreset (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .d_i     (txnreset_async_i),
        .q_o     (txnreset_o)
    );
    qspi_cdc_fifo_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .clear_i   (fifo_clear_i),
        .wr_i      (wr_i),
        .wr_data_i (wr_data_i),
        .rd_i      (rd_i),
        .rd_data_o (rd_data_o),
        .full_o    (full_o),
        .empty_o   (empty_o),
        .filled_o  (filled_o)
    );
endmodule

// File: tb/tb_qspi_cdc_fifo.sv
// tb_qspi_cdc_fifo: directed stimulus checked against a queue-based reference model
module tb_qspi_cdc_fifo;
    localparam int W = 16;
    localparam int D = 16;

    logic         clk = 1'b0;
    logic         reset_i = 1'b1;
    logic         done_async_i = 1'b0;
    logic         txnreset_async_i = 1'b1;
    logic         fifo_clear_i = 1'b0;
    logic         wr_i = 1'b0;
    logic [W-1:0] wr_data_i = '0;
    logic         rd_i = 1'b0;
    logic         done_o, done_pe_o, done_ne_o, txnreset_o, full_o, empty_o;
    logic [W-1:0] rd_data_o;
    logic [4:0]   filled_o;

    int total = 0;
    int passed = 0;
    bit en = 1'b0;

    qspi_cdc_fifo #(.WIDTH(W), .DEPTH(D), .TXNRESET_INIT(1'b1)) dut (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .done_async_i     (done_async_i),
        .done_o           (done_o),
        .done_pe_o        (done_pe_o),
        .done_ne_o        (done_ne_o),
        .txnreset_async_i (txnreset_async_i),
        .txnreset_o       (txnreset_o),
        .fifo_clear_i     (fifo_clear_i),
        .wr_i             (wr_i),
        .wr_data_i        (wr_data_i),
        .rd_i             (rd_i),
        .rd_data_o        (rd_data_o),
        .full_o           (full_o),
        .empty_o          (empty_o),
        .filled_o         (filled_o)
    );

    always #5 clk = ~clk;

    // reference model: input histories for the synchronizers, a word queue for the FIFO
    logic [W-1:0] mq[$];
    logic [W-1:0] m_rd = '0;
    logic         dh[$];
    logic         th[$];

    always @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            mq.delete();
            m_rd = '0;
            dh = '{1'b0, 1'b0, 1'b0};
            th = '{1'b1, 1'b1};
        end else begin
            bit rok, wok;
            dh.push_back(done_async_i);
            if (dh.size() > 3) void'(dh.pop_front());
            th.push_back(txnreset_async_i);
            if (th.size() > 2) void'(th.pop_front());
            if (fifo_clear_i) begin
                mq.delete();
                m_rd = '0;
            end else begin
                rok = rd_i && mq.size() > 0;
                wok = wr_i && (mq.size() < D || rok);
                if (rok) m_rd = mq.pop_front();
                if (wok) mq.push_back(wr_data_i);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // every cycle: all outputs against the model
    always @(negedge clk) begin
        if (en) begin
            chk("m_done", 32'(done_o), 32'(dh[1]));
            chk("m_done_pe", 32'(done_pe_o), 32'(dh[1] & ~dh[0]));
            chk("m_done_ne", 32'(done_ne_o), 32'(~dh[1] & dh[0]));
            chk("m_txnreset", 32'(txnreset_o), 32'(th[0]));
            chk("m_rd_data", 32'(rd_data_o), 32'(m_rd));
            chk("m_filled", 32'(filled_o), 32'(mq.size()));
            chk("m_empty", 32'(empty_o), 32'(mq.size() == 0));
            chk("m_full", 32'(full_o), 32'(mq.size() == D));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] d);
        wr_i = 1'b1;
        wr_data_i = d;
        tick();
        wr_i = 1'b0;
    endtask

    task automatic pop;
        rd_i = 1'b1;
        tick();
        rd_i = 1'b0;
    endtask

    initial begin
        repeat (3) tick();
        reset_i = 1'b0;
        en = 1'b1;
        chk("rst_txnreset", 32'(txnreset_o), 32'd1);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_empty", 32'(empty_o), 32'd1);
        chk("rst_filled", 32'(filled_o), 32'd0);
        chk("rst_rd_data", 32'(rd_data_o), 32'd0);
        txnreset_async_i = 1'b0;
        tick();
        chk("txn_lat1", 32'(txnreset_o), 32'd1);
        tick();
        chk("txn_lat2", 32'(txnreset_o), 32'd0);

        done_async_i = 1'b1;
        tick();
        chk("done_lat1", 32'(done_o), 32'd0);
        tick();
        chk("done_rise", 32'(done_o), 32'd1);
        chk("done_pe", 32'(done_pe_o), 32'd1);
        tick();
        chk("done_pe_once", 32'(done_pe_o), 32'd0);
        chk("done_hold", 32'(done_o), 32'd1);
        repeat (2) tick();
        done_async_i = 1'b0;
        tick();
        chk("done_fall_lat1", 32'(done_o), 32'd1);
        chk("done_ne_early", 32'(done_ne_o), 32'd0);
        tick();
        chk("done_fall", 32'(done_o), 32'd0);
        chk("done_ne", 32'(done_ne_o), 32'd1);
        tick();
        chk("done_ne_once", 32'(done_ne_o), 32'd0);

        push(16'h1111);
        push(16'h2222);
        push(16'h3333);
        chk("three_filled", 32'(filled_o), 32'd3);
        pop();
        chk("rd_1111", 32'(rd_data_o), 32'h1111);
        pop();
        chk("rd_2222", 32'(rd_data_o), 32'h2222);
        tick();
        chk("rd_hold", 32'(rd_data_o), 32'h2222);
        pop();
        chk("rd_3333", 32'(rd_data_o), 32'h3333);
        chk("three_empty", 32'(empty_o), 32'd1);
        pop();
        chk("rd_empty_ignored", 32'(rd_data_o), 32'h3333);

        for (int i = 0; i < 16; i++) push(16'(i));
        chk("full_flag", 32'(full_o), 32'd1);
        chk("full_filled", 32'(filled_o), 32'd16);
        push(16'hFFFF);
        chk("wr_full_ignored", 32'(filled_o), 32'd16);
        rd_i = 1'b1;
        push(16'hAAAA);
        rd_i = 1'b0;
        chk("rdwr_full_filled", 32'(filled_o), 32'd16);
        chk("rdwr_full_data", 32'(rd_data_o), 32'h0000);
        for (int i = 1; i < 16; i++) begin
            pop();
            chk("drain", 32'(rd_data_o), 32'(i));
        end
        pop();
        chk("drain_wrap", 32'(rd_data_o), 32'hAAAA);
        chk("drain_empty", 32'(empty_o), 32'd1);

        rd_i = 1'b1;
        push(16'h5A5A);
        rd_i = 1'b0;
        chk("rdwr_empty_data", 32'(rd_data_o), 32'hAAAA);
        chk("rdwr_empty_filled", 32'(filled_o), 32'd1);
        pop();
        chk("rdwr_empty_read", 32'(rd_data_o), 32'h5A5A);

        for (int i = 0; i < 4; i++) push(16'hC000 + 16'(i));
        fifo_clear_i = 1'b1;
        push(16'hDEAD);
        fifo_clear_i = 1'b0;
        chk("clr_filled", 32'(filled_o), 32'd0);
        chk("clr_empty", 32'(empty_o), 32'd1);
        chk("clr_rd_data", 32'(rd_data_o), 32'd0);
        chk("clr_txn_kept", 32'(txnreset_o), 32'd0);

        push(16'hBEEF);
        push(16'h1234);
        pop();
        done_async_i = 1'b1;
        repeat (3) tick();
        chk("pre_rst_data", 32'(rd_data_o), 32'hBEEF);
        chk("pre_rst_done", 32'(done_o), 32'd1);
        #2;
        reset_i = 1'b1;
        #1;
        chk("arst_filled", 32'(filled_o), 32'd0);
        chk("arst_empty", 32'(empty_o), 32'd1);
        chk("arst_full", 32'(full_o), 32'd0);
        chk("arst_rd_data", 32'(rd_data_o), 32'd0);
        chk("arst_done", 32'(done_o), 32'd0);
        chk("arst_txn", 32'(txnreset_o), 32'd1);
        repeat (2) tick();
        reset_i = 1'b0;
        repeat (4) tick();
        en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/qspi_cdc_fifo.md
Name: qspi_cdc_fifo

Overview:
- Clock-domain-crossing and buffering front end for the QSPI bridge controller FSM.
- Synchronizes two asynchronous SPI-side level signals into the system clock domain:
  - the word-done strobe, with edge detection;
  - the transaction reset (CE deasserted), which has a configurable reset value.
- Provides a synchronous first-word-registered FIFO that buffers sequential read data between the Wishbone side and the SPI shift register.

Parameters:
- WIDTH, 16, FIFO data width in bits.
- DEPTH, 16, FIFO depth in words; power of two, at least 2.
- TXNRESET_INIT, 1, value the transaction-reset synchronizer holds during reset.

Ports:
- clk_i  in  1  system clock; all logic is rising-edge.
- reset_i  in  1  asynchronous, active-high reset.
- done_async_i  in  1  asynchronous word-done level from the SPI domain.
- done_o  out  1  synchronized done level.
- done_pe_o  out  1  one-cycle pulse on the rising edge of done_o.
- done_ne_o  out  1  one-cycle pulse on the falling edge of done_o.
- txnreset_async_i  in  1  asynchronous transaction reset (CE high).
- txnreset_o  out  1  synchronized transaction reset.
- fifo_clear_i  in  1  synchronous FIFO flush.
- wr_i  in  1  FIFO write enable.
- wr_data_i  in  WIDTH  FIFO write data.
- rd_i  in  1  FIFO read enable.
- rd_data_o  out  WIDTH  registered read data.
- full_o  out  1  FIFO holds DEPTH words.
- empty_o  out  1  FIFO holds 0 words.
- filled_o  out  $clog2(DEPTH)+1  current word count, 0..DEPTH.

Behaviour:
- Reset values (reset_i high, asynchronous):
  - done_o, done_pe_o, done_ne_o = 0;
  - txnreset_o = TXNRESET_INIT;
  - FIFO pointers and count = 0, so filled_o = 0, empty_o = 1, full_o = 0;
  - rd_data_o = 0.
- Done synchronizer:
  - Two flops in series, plus a third "previous" flop.
  - done_o equals the second flop; a change on done_async_i appears on done_o 2 clocks later.
  - done_pe_o = done_o & ~prev; done_ne_o = ~done_o & prev. Both are combinational from registers.
  - Each pulse lasts exactly one cycle per edge.
- Txnreset synchronizer:
  - Two flops, both resetting to TXNRESET_INIT.
  - Latency is 2 clocks; no edge outputs.
- FIFO write:
  - On wr_i with full_o = 0, store wr_data_i at the write pointer and advance the pointer.
  - Pointers wrap modulo DEPTH.
- FIFO read:
  - On rd_i with empty_o = 0, rd_data_o is registered with the head word on that clock edge and the read pointer advances.
  - rd_data_o is therefore valid from the cycle after rd_i and holds until the next accepted read.
- Rejected operations:
  - rd_i while empty_o = 1 is ignored; rd_data_o holds.
  - wr_i while full_o = 1 is ignored, unless rd_i is accepted in the same cycle, in which case both occur and the count is unchanged.
- Simultaneous rd_i and wr_i:
  - When empty: the read is ignored and the write is accepted; the count goes to 1. There is no write-to-read bypass.
  - Otherwise: both occur and the count is unchanged.
- filled_o, empty_o and full_o are derived from a registered count and reflect all accepted operations from the next cycle.
- fifo_clear_i:
  - Zeroes the pointers and count on the next edge, with priority over rd_i and wr_i in the same cycle.
  - rd_data_o is cleared to 0.
  - It does not affect either synchronizer.
- The FIFO storage array has no reset; only the pointers, count and rd_data_o reset.

Decomposition:
- Shared package: no typedefs; the FIFO count width $clog2(DEPTH)+1 is computed locally.
- Sub-modules:
  - a two-flop synchronizer with reset-value parameter, instantiated for txnreset;
  - an edge-detecting synchronizer wrapping the same two-flop core, for done;
  - the FIFO as its own sub-module.
- The top only wires these together.

Test Plan:
- Reset with TXNRESET_INIT=1, then release → txnreset_o=1, done_o=0, empty_o=1, filled_o=0, rd_data_o=0. Drive txnreset_async_i=0 → txnreset_o=0 exactly 2 clocks later.
- done_async_i 0→1, held 5 cycles, then 1→0:
  - done_o rises 2 clocks after the input edge, with done_pe_o=1 for exactly that one cycle;
  - done_ne_o pulses once, 2 clocks after the falling edge.
- Write 0x1111, 0x2222, 0x3333 → filled_o=3. Read three times → rd_data_o shows 0x1111, 0x2222, 0x3333 on the cycle after each rd_i, and empty_o=1 at the end.
- Write 16 words (0x0000..0x000F) → full_o=1, filled_o=16.
  - A 17th write of 0xFFFF is ignored.
  - Simultaneous rd+wr of 0xAAAA while full → filled_o stays 16 and rd_data_o=0x0000.
  - Draining returns 0x0001..0x000F and then 0xAAAA (pointer wrap verified).
- Empty FIFO with simultaneous rd_i and wr_i of 0x5A5A → rd_data_o unchanged and filled_o=1. A read the next cycle yields 0x5A5A.
- Four words queued, assert fifo_clear_i with wr_i in the same cycle → filled_o=0, empty_o=1, rd_data_o=0. Assert reset_i mid-stream → all outputs return to reset values immediately, without waiting for a clock edge.
